// File: rtl/sim_run_controller.sv
// Run controller for single-cycle CPU test systems: sequences CPU reset, counts RUN cycles and stores,
// and ends the run on a tohost store, a PC self-loop (HALT) or a cycle timeout.
module sim_run_controller #(
    parameter int unsigned        ADDR_W       = 32,
    parameter int unsigned        DATA_W       = 32,
    parameter int unsigned        CNT_W        = 32,
    parameter int unsigned        RESET_CYCLES = 1,
    parameter int unsigned        MAX_CYCLES   = 300,
    parameter int unsigned        STALL_CYCLES = 4,
    parameter logic [ADDR_W-1:0]  TOHOST_ADDR  = ADDR_W'(32'hFC)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              restart,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] address_to_mem,
    input  logic [DATA_W-1:0] data_to_mem,
    input  logic [ADDR_W-1:0] pc,
    output logic              cpu_reset,
    output logic              running,
    output logic              done,
    output logic [1:0]        status,
    output logic [DATA_W-1:0] exit_code,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  store_count
);

    // state  | meaning
    // S_HOLD | CPU held in reset for RESET_CYCLES cycles
    // S_RUN  | CPU running; counting cycles/stores, watching for an end condition
    // S_DONE | run finished; outputs frozen until restart or reset
    typedef enum logic [1:0] {S_HOLD, S_RUN, S_DONE} state_t;

    localparam int unsigned HOLD_W  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int unsigned STALL_W = $clog2(STALL_CYCLES);

    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CYCLE_LAST = CNT_W'(MAX_CYCLES - 1);

    localparam logic [1:0] ST_NONE    = 2'd0;
    localparam logic [1:0] ST_TOHOST  = 2'd1;
    localparam logic [1:0] ST_HALT    = 2'd2;
    localparam logic [1:0] ST_TIMEOUT = 2'd3;

    state_t             state;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [STALL_W-1:0] stall_cnt;
    logic [ADDR_W-1:0]  last_pc;
    logic               pc_valid;

    logic               tohost_hit;
    logic               halt_hit;
    logic               timeout_hit;
    logic [STALL_W-1:0] stall_next;
    logic [CNT_W-1:0]   cycle_next;
    logic [CNT_W-1:0]   store_next;

    // pc_valid keeps the first RUN cycle from comparing against a stale or reset-time PC
    always_comb begin
        tohost_hit  = write_enable && (address_to_mem == TOHOST_ADDR);
        stall_next  = (pc_valid && (pc == last_pc)) ? stall_cnt + STALL_W'(1) : '0;
        halt_hit    = (stall_next == STALL_LAST);
        timeout_hit = (cycle_count == CYCLE_LAST);
        cycle_next  = (&cycle_count) ? cycle_count : cycle_count + CNT_W'(1);
        store_next  = (write_enable && !(&store_count)) ? store_count + CNT_W'(1) : store_count;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_HOLD;
            hold_cnt    <= '0;
            stall_cnt   <= '0;
            last_pc     <= '0;
            pc_valid    <= 1'b0;
            cpu_reset   <= 1'b1;
            running     <= 1'b0;
            done        <= 1'b0;
            status      <= ST_NONE;
            exit_code   <= '0;
            cycle_count <= '0;
            store_count <= '0;
        end else if (restart) begin
            state       <= S_HOLD;
            hold_cnt    <= '0;
            stall_cnt   <= '0;
            pc_valid    <= 1'b0;
            cpu_reset   <= 1'b1;
            running     <= 1'b0;
            done        <= 1'b0;
            status      <= ST_NONE;
            exit_code   <= '0;
            cycle_count <= '0;
            store_count <= '0;
        end else begin
            case (state)
                S_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state     <= S_RUN;
                        hold_cnt  <= '0;
                        cpu_reset <= 1'b0;
                        running   <= 1'b1;
                    end else begin
                        hold_cnt  <= hold_cnt + HOLD_W'(1);
                    end
                end
                S_RUN: begin
                    cycle_count <= cycle_next;
                    store_count <= store_next;
                    last_pc     <= pc;
                    pc_valid    <= 1'b1;
                    stall_cnt   <= stall_next;
                    if (tohost_hit || halt_hit || timeout_hit) begin
                        state   <= S_DONE;
                        running <= 1'b0;
                        done    <= 1'b1;
                        if (tohost_hit) begin
                            status    <= ST_TOHOST;
                            exit_code <= data_to_mem;
                        end else if (halt_hit) begin
                            status    <= ST_HALT;
                        end else begin
                            status    <= ST_TIMEOUT;
                        end
                    end
                end
                S_DONE: ;
                default: state <= S_HOLD;
            endcase
        end
    end

endmodule

// File: tb/tb_sim_run_controller.sv
// Randomized bench for sim_run_controller: per-run stimulus tables are scored by a model that
// scans the table for the first tohost store, PC run of STALL cycles, or timeout.
module tb_sim_run_controller;

    localparam int MAX   = 300;
    localparam int STALL = 4;
    localparam int NMAX  = MAX + 8;
    localparam logic [31:0] TOHOST = 32'hFC;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        restart = 1'b0;
    logic        write_enable = 1'b0;
    logic [31:0] address_to_mem = '0;
    logic [31:0] data_to_mem = '0;
    logic [31:0] pc = '0;

    logic        cpu_reset, running, done;
    logic [1:0]  status;
    logic [31:0] exit_code, cycle_count, store_count;

    logic        cpu_reset3, running3, done3;
    logic [1:0]  status3;
    logic [31:0] exit_code3, cycle_count3, store_count3;

    sim_run_controller dut (
        .clk(clk), .reset(reset), .restart(restart), .write_enable(write_enable),
        .address_to_mem(address_to_mem), .data_to_mem(data_to_mem), .pc(pc),
        .cpu_reset(cpu_reset), .running(running), .done(done), .status(status),
        .exit_code(exit_code), .cycle_count(cycle_count), .store_count(store_count)
    );

    sim_run_controller #(.RESET_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset), .restart(restart), .write_enable(write_enable),
        .address_to_mem(address_to_mem), .data_to_mem(data_to_mem), .pc(pc),
        .cpu_reset(cpu_reset3), .running(running3), .done(done3), .status(status3),
        .exit_code(exit_code3), .cycle_count(cycle_count3), .store_count(store_count3)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // length of the cpu_reset pulse of the RESET_CYCLES=3 instance, measured on falling edges
    int h3_cnt = 0;
    int h3_len = 0;
    int h3_seq = 0;
    always @(negedge clk) begin
        if (reset && cpu_reset3) begin
            h3_cnt <= h3_cnt + 1;
        end else if (h3_cnt != 0) begin
            h3_len <= h3_cnt;
            h3_seq <= h3_seq + 1;
            h3_cnt <= 0;
        end
    end

    logic [31:0] s_pc   [NMAX];
    logic [31:0] s_addr [NMAX];
    logic [31:0] s_data [NMAX];
    bit          s_we   [NMAX];

    int          exp_end, exp_status, exp_cyc, exp_st;
    logic [31:0] exp_exit;

    // kind 0 tohost at t, 1 pc frozen from t, 2 timeout, 3 tohost+halt+timeout together,
    // 4 halt+timeout together, 5 random pc pair with rare tohost stores
    task automatic gen(input int kind, input int t, input logic [31:0] d);
        logic [31:0] base;
        base = 32'h1000 + ($urandom % 256) * 4;
        for (int k = 0; k < NMAX; k++) begin
            s_pc[k]   = base + 32'(k) * 4;
            s_we[k]   = ($urandom % 3) == 0;
            s_addr[k] = $urandom & 32'h0000_0FFC;
            if (s_addr[k] == TOHOST) s_addr[k] = 32'hF8;
            s_data[k] = $urandom;
            case (kind)
                0: if (k == t) begin s_we[k] = 1; s_addr[k] = TOHOST; s_data[k] = d; end
                   else if (k == t - 1) begin s_we[k] = 1; s_addr[k] = 32'hF8; end
                1: if (k >= t) s_pc[k] = 32'h40;
                3: begin
                    if (k >= MAX - STALL) s_pc[k] = 32'h40;
                    if (k == MAX - 1) begin s_we[k] = 1; s_addr[k] = TOHOST; s_data[k] = d; end
                end
                4: if (k >= MAX - STALL) s_pc[k] = 32'h40;
                5: begin
                    s_pc[k] = 32'h40 + 32'(($urandom % 2) * 4);
                    if (($urandom % 32) == 0) s_addr[k] = TOHOST;
                end
                default: ;
            endcase
        end
    endtask

    task automatic model();
        int run_len;
        int stores;
        bit th, hl, to;
        exp_end = -1; exp_status = 0; exp_exit = 0; exp_cyc = 0; exp_st = 0;
        run_len = 0; stores = 0;
        for (int k = 0; k < NMAX; k++) begin
            run_len = (k > 0 && s_pc[k] == s_pc[k-1]) ? run_len + 1 : 1;
            if (s_we[k]) stores++;
            th = s_we[k] && s_addr[k] == TOHOST;
            hl = run_len >= STALL;
            to = k + 1 >= MAX;
            if (th || hl || to) begin
                exp_end    = k;
                exp_cyc    = k + 1;
                exp_st     = stores;
                exp_status = th ? 1 : (hl ? 2 : 3);
                exp_exit   = th ? s_data[k] : 32'h0;
                break;
            end
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_cpu_reset"}, cpu_reset, 1);
        check({tag, "_running"}, running, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_status"}, status, 0);
        check({tag, "_exit"}, exit_code, 0);
        check({tag, "_cycles"}, cycle_count, 0);
        check({tag, "_stores"}, store_count, 0);
        check({tag, "_cpu_reset3"}, cpu_reset3, 1);
    endtask

    // bus shows a tohost store while held: it must be ignored
    task automatic garbage_bus();
        write_enable = 1; address_to_mem = TOHOST; data_to_mem = $urandom; pc = s_pc[0];
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 reset = 0;
        garbage_bus();
        #1 check_cleared("reset");
        @(posedge clk);
        #2 reset = 1;
    endtask

    task automatic do_restart();
        @(negedge clk);
        restart = 1;
        garbage_bus();
        @(posedge clk);
        #2 restart = 0;
        #1 check_cleared("restart");
    endtask

    task automatic play(input int abort_at);
        int hc, act_end, seq0;
        seq0 = h3_seq;
        model();
        hc = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (cpu_reset) hc++;
            else break;
        end
        check("hold_len", hc, 1);
        check("run_start", running, 1);
        act_end = -1;
        for (int k = 0; k < NMAX; k++) begin
            if (abort_at >= 0 && k == abort_at) break;
            pc = s_pc[k]; write_enable = s_we[k]; address_to_mem = s_addr[k]; data_to_mem = s_data[k];
            @(posedge clk);
            @(negedge clk);
            if (done) begin act_end = k; break; end
        end
        if (abort_at >= 0) begin
            check("abort_cycles", cycle_count, abort_at);
            check("abort_running", running, 1);
        end else begin
            check("end_cycle", act_end, exp_end);
            check("status", status, exp_status);
            check("exit_code", exit_code, exp_exit);
            check("cycle_count", cycle_count, exp_cyc);
            check("store_count", store_count, exp_st);
            check("end_running", running, 0);
            check("end_cpu_reset", cpu_reset, 0);
            for (int i = 0; i < 3; i++) begin
                pc = 32'h40; write_enable = 1; address_to_mem = TOHOST; data_to_mem = ~exp_exit;
                @(posedge clk);
                @(negedge clk);
            end
            check("hold_done", done, 1);
            check("hold_status", status, exp_status);
            check("hold_exit", exit_code, exp_exit);
            check("hold_cycles", cycle_count, exp_cyc);
            check("hold_stores", store_count, exp_st);
        end
        check("hold3_len", (h3_seq != seq0) ? h3_len : 0, 3);
    endtask

    initial begin
        int kind;
        gen(0, 20, 32'h0);
        do_reset();
        play(-1);
        check("t1_cycles", cycle_count, 21);

        gen(0, 5 + int'($urandom % 100), 32'h5);
        do_restart();
        play(-1);

        gen(1, 10, 32'h0);
        do_restart();
        play(-1);

        gen(2, 0, 32'h0);
        do_restart();
        play(-1);

        gen(3, 0, $urandom | 32'h1);
        do_restart();
        play(-1);

        gen(4, 0, 32'h0);
        do_restart();
        play(-1);

        gen(2, 0, 32'h0);
        do_restart();
        play(50);
        gen(0, int'($urandom % 250), $urandom);
        do_restart();
        play(-1);

        gen(2, 0, 32'h0);
        do_restart();
        play(60);
        gen(5, 0, 32'h0);
        do_reset();
        play(-1);

        for (int r = 0; r < 8; r++) begin
            kind = int'($urandom % 3);
            if (kind == 2) kind = 5;
            gen(kind, int'($urandom % 280), $urandom);
            do_restart();
            play(-1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
